serial_subtractor5: RTL and testbench
=====================================

// Module: serial_subtractor5
// PURPOSE
//  - Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, with borrow-out Bout.
//  - Inverse operation to the team's parallel adder datapath.
//  - Trades area for latency: one subtract slice plus a borrow flop, driven by a small controller FSM.
//  - Sits beside the adder in the CA2 datapath and is driven by a start/done handshake.
// PARAMETERS
//  - WIDTH  5  operand/result width in bits; must be >= 2
// PORTS
//  - clk    in   1      single clock; all state updates on its rising edge
//  - rst    in   1      asynchronous, active-high reset
//  - start  in   1      request; sampled only in IDLE
//  - A      in   WIDTH  minuend; captured on the accepting edge
//  - B      in   WIDTH  subtrahend; captured on the accepting edge
//  - Bin    in   1      borrow-in; captured on the accepting edge
//  - Diff   out  WIDTH  result; held stable from done until the next completion
//  - Bout   out  1      borrow-out (1 = unsigned underflow)
//  - busy   out  1      high in SHIFT and DONE
//  - done   out  1      one-cycle pulse; result valid from this cycle onward
//  - ovf    out  1      signed overflow (present only with SERIAL_SUB_OVF_EN)
// BEHAVIOUR
//  - Reset: async rst forces state=IDLE and clears Diff, Bout, busy, done, ovf, count, internal shift regs and borrow flop to 0.
//    - Reset mid-operation aborts the operation; no done pulse follows.
//  - FSM states and transitions:
//    - IDLE -> SHIFT on an edge where start=1.
//    - SHIFT -> SHIFT while count < WIDTH-1.
//    - SHIFT -> DONE on the edge where count == WIDTH-1.
//    - DONE -> IDLE unconditionally.
//  - Accept edge (IDLE, start=1):
//    - load shA <= A, shB <= B.
//    - carry flop <= ~Bin (two's-complement form).
//    - count <= 0.
//  - SHIFT, each edge:
//    - s = shA[0] ^ ~shB[0] ^ c;  c <= majority(shA[0], ~shB[0], c).
//    - Result shift reg shifts right with s entering at MSB; shA and shB shift right.
//    - count++.
//  - Completion: on the edge leaving the last SHIFT cycle:
//    - Diff <= assembled result.
//    - Bout <= ~(final carry).
//  - Timing: accept at edge k, bits processed on edges k+1..k+WIDTH.
//    - done=1 during the cycle after edge k+WIDTH (i.e. WIDTH+1 cycles after accept).
//    - Returns to IDLE at edge k+WIDTH+1; a back-to-back start is accepted there at the earliest.
//  - start while busy (SHIFT or DONE) is ignored: no queueing, no restart.
//  - Operands may change freely after the accept edge without affecting the result.
//  - Arithmetic is modulo 2^WIDTH; Bout=1 iff A < B + Bin (unsigned compare).
//  - Diff/Bout are never updated except at completion; between operations they hold the last result.
// CONFIGURATION
//  - Macro SERIAL_SUB_OVF_EN:
//    - Defined: adds port ovf.
//      - ovf = carry-into-MSB XOR carry-out-of-MSB of the last slice operation.
//      - Registered alongside Diff; same validity/hold rules; reset 0.
//    - Undefined: ovf port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package serial_sub_pkg:
//    - localparam state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
//    - counter width function clog2(WIDTH).
//  - Sub-module sub_bit_slice: combinational (a, b, cin) -> (d, cout), computing a + ~b + cin.
//    - Instantiated once.
//  - Top module holds the FSM, count, operand/result shift registers and the carry flop.
// TESTING
//  - A=10110, B=00101, Bin=0 -> done at cycle 6 after accept; Diff=10001, Bout=0.
//  - A=00011, B=00101, Bin=0 -> Diff=11110, Bout=1 (ovf=0 when enabled).
//  - A=00000, B=00000, Bin=1 -> Diff=11111, Bout=1.
//  - OVF_EN build: A=10000, B=00001, Bin=0 -> Diff=01111, Bout=0, ovf=1.
//  - Start accepted (A=01010, B=00011); pulse start again mid-SHIFT with other operands
//    -> ignored; single done; Diff=00111.
//  - Assert rst two cycles after accept -> all outputs 0 immediately, no done.
//    - Next start then completes normally.

Source files
------------

// File: rtl/serial_subtractor5_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..v-1 (v >= 2).
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = int'(i) + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor5_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor5_if #(parameter int WIDTH = 5);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, A, B, Bin, input Diff, Bout, busy, done, ovf);
    modport slave  (input start, A, B, Bin, output Diff, Bout, busy, done, ovf);
`else
    modport master (output start, A, B, Bin, input Diff, Bout, busy, done);
    modport slave  (input start, A, B, Bin, output Diff, Bout, busy, done);
`endif

endinterface

// File: rtl/serial_subtractor5_slice.sv
// One-bit subtract slice: a + ~b + cin, giving difference bit and carry.
module sub_bit_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic d,
    output logic cout
);

    logic nb;

    assign nb   = ~b;
    assign d    = a ^ nb ^ cin;
    assign cout = (a & nb) | (a & cin) | (nb & cin);

endmodule

// File: rtl/serial_subtractor5.sv
// Bit-serial WIDTH-bit subtractor (Diff = A - B - Bin) with start/done handshake.
// Defining SERIAL_SUB_OVF_EN adds the registered signed-overflow flag ovf.
module serial_subtractor5
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor5_if.slave bus
);

    localparam int CW = clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sha, shb;
    logic [WIDTH-2:0] res;
    logic             c;
    logic             s, cout;
    logic             last;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    sub_bit_slice u_slice (
        .a    (sha[0]),
        .b    (shb[0]),
        .cin  (c),
        .d    (s),
        .cout (cout)
    );

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT: begin
                bus.busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // res holds only the upper WIDTH-1 result bits; the final slice output is
    // merged in directly when Diff is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sha    <= '0;
            shb    <= '0;
            res    <= '0;
            c      <= 1'b0;
            count  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sha   <= bus.A;
                        shb   <= bus.B;
                        c     <= ~bus.Bin;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    c     <= cout;
                    sha   <= sha >> 1;
                    shb   <= shb >> 1;
                    res   <= (res >> 1) | ((WIDTH-1)'(s) << (WIDTH - 2));
                    count <= count + 1'b1;
                    if (last) begin
                        diff_q <= {s, res};
                        bout_q <= ~cout;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q  <= c ^ cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor5.sv
// Self-checking bench for serial_subtractor5: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_subtractor5;

    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_count = 0;

    always #5 clk = ~clk;

    serial_subtractor5_if #(.WIDTH(W)) bus ();

    serial_subtractor5 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.done === 1'b1) done_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
        int d, sd;
        d  = int'(a) - int'(b) - int'(bin);
        ed = W'(d);
        eb = (d < 0);
        sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
        eo = (sd > (2**(W-1)) - 1) || (sd < -(2**(W-1)));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit poke);
        logic [W-1:0] ed;
        logic eb, eo;
        int cyc, d0;
        model(a, b, bin, ed, eb, eo);
        @(negedge clk);
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.Bin = 1'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        d0  = done_count;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 4 * W) begin
            if (poke && cyc == 1) begin
                bus.start = 1'b1; bus.A = ~a; bus.B = ~b; bus.Bin = ~bin;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("latency", 32'(cyc), 32'(W));
        check("diff", 32'(bus.Diff), 32'(ed));
        check("bout", 32'(bus.Bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(eo));
`endif
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("single_done", 32'(done_count - d0), 32'd1);
        check("diff_hold", 32'(bus.Diff), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst = 1'b1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        #12;
        check("rst_diff", 32'(bus.Diff), 32'd0);
        check("rst_bout", 32'(bus.Bout), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(5'b10110, 5'b00101, 1'b0, 1'b0);
        run_op(5'b00011, 5'b00101, 1'b0, 1'b0);
        run_op(5'b00000, 5'b00000, 1'b1, 1'b0);
        run_op(5'b10000, 5'b00001, 1'b0, 1'b0);
        run_op(5'b01010, 5'b00011, 1'b0, 1'b1);

        // Abort mid-operation with async reset.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 5'b01100; bus.B = 5'b00001; bus.Bin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_diff", 32'(bus.Diff), 32'd0);
        check("abort_bout", 32'(bus.Bout), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk); rst = 1'b0;
        d0 = done_count;
        repeat (W + 3) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(done_count - d0), 32'd0);
        run_op(5'b11001, 5'b00110, 1'b1, 1'b0);

        repeat (25) run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
